// File: rtl/vga_pkg.sv
// Shared VGA scan-out types and helpers: timing totals, ordered-dither
// threshold generation and the saturating dither quantiser.
package vga_pkg;

    localparam int X_BITS = 11;
    localparam int Y_BITS = 10;
    localparam int F_BITS = 11;

    // Per-pixel control that must travel alongside the upstream colour latency.
    typedef struct packed {
        logic       active;
        logic       hs;
        logic       vs;
        logic [2:0] xs;
        logic [2:0] ys;
        logic       f0;
    } pix_meta_t;

    function automatic int total4(input int a, input int b, input int c, input int d);
        return a + b + c + d;
    endfunction

    // 8x8 Bayer rank; only y[2:1] participate, y[0] is irrelevant to this matrix.
    function automatic logic [4:0] bayer5(input logic [2:0] xs, input logic [2:1] ys,
                                          input logic f0);
        logic [2:0] i;
        i = xs ^ {3{f0}};
        return {i[0], i[1] ^ ys[1], i[1], i[2] ^ ys[2], i[2]};
    endfunction

    function automatic int unsigned dither_sat(input int unsigned c, input int unsigned t,
                                               input int unsigned s,
                                               input int unsigned out_bits);
        int unsigned q;
        int unsigned top;
        q   = (c + t) >> s;
        top = (32'd1 << out_bits) - 32'd1;
        return (q > top) ? top : q;
    endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Fixed-depth shift register with async clear; depth 0 collapses to a wire.
module vga_delay_line #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    generate
        if (DEPTH == 0) begin : g_wire
            logic unused_clk_rst;
            assign unused_clk_rst = clk ^ rst;
            assign q_o = d_i;
        end else begin : g_regs
            logic [WIDTH-1:0] stage_q [DEPTH];

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
                end else begin
                    stage_q[0] <= d_i;
                    for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
                end
            end

            assign q_o = stage_q[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/vga_scanout.sv
// VGA raster timing generator with LAT-aligned sync/DE and Bayer-dithered
// colour reduction from IN_BITS to OUT_BITS per channel.
module vga_scanout
    import vga_pkg::*;
#(
    parameter int   H_DISPLAY = 1220,
    parameter int   H_FRONT   = 31,
    parameter int   H_SYNC    = 183,
    parameter int   H_BACK    = 92,
    parameter int   V_DISPLAY = 480,
    parameter int   V_FRONT   = 10,
    parameter int   V_SYNC    = 2,
    parameter int   V_BACK    = 33,
    parameter logic HSYNC_POL = 1'b0,
    parameter logic VSYNC_POL = 1'b0,
    parameter int   IN_BITS   = 6,
    parameter int   OUT_BITS  = 2,
    parameter int   LAT       = 2
) (
    input  logic                clk48,
    input  logic                rst,
    input  logic                pause_n,
    output logic [X_BITS-1:0]   x,
    output logic [Y_BITS-1:0]   y,
    output logic [F_BITS-1:0]   frame,
    output logic                line_start,
    output logic                frame_start,
    input  logic [IN_BITS-1:0]  r_in,
    input  logic [IN_BITS-1:0]  g_in,
    input  logic [IN_BITS-1:0]  b_in,
    output logic                hsync,
    output logic                vsync,
    output logic                de,
    output logic [OUT_BITS-1:0] r_out,
    output logic [OUT_BITS-1:0] g_out,
    output logic [OUT_BITS-1:0] b_out
);

    localparam int H_TOTAL = total4(H_DISPLAY, H_FRONT, H_SYNC, H_BACK);
    localparam int V_TOTAL = total4(V_DISPLAY, V_FRONT, V_SYNC, V_BACK);
    localparam int SHIFT   = IN_BITS - OUT_BITS;

    generate
        if (SHIFT < 1 || SHIFT > 5 || LAT < 0 || LAT > 15 ||
            H_TOTAL > 2047 || V_TOTAL > 1023) begin : g_bad_params
            $error("vga_scanout: unsupported parameter combination");
        end
    endgenerate

    localparam logic [X_BITS-1:0] H_LAST = X_BITS'(H_TOTAL - 1);
    localparam logic [X_BITS-1:0] H_ACT  = X_BITS'(H_DISPLAY);
    localparam logic [X_BITS-1:0] HS_BEG = X_BITS'(H_DISPLAY + H_FRONT);
    localparam logic [X_BITS-1:0] HS_END = X_BITS'(H_DISPLAY + H_FRONT + H_SYNC);
    localparam logic [Y_BITS-1:0] V_LAST = Y_BITS'(V_TOTAL - 1);
    localparam logic [Y_BITS-1:0] V_ACT  = Y_BITS'(V_DISPLAY);
    localparam logic [Y_BITS-1:0] VS_BEG = Y_BITS'(V_DISPLAY + V_FRONT);
    localparam logic [Y_BITS-1:0] VS_END = Y_BITS'(V_DISPLAY + V_FRONT + V_SYNC);

    logic [X_BITS-1:0] x_q, x_d;
    logic [Y_BITS-1:0] y_q, y_d;
    logic [F_BITS-1:0] frame_q, frame_d;
    logic              x_wrap, y_wrap;

    always_comb begin
        x_wrap  = (x_q == H_LAST);
        y_wrap  = (y_q == V_LAST);
        x_d     = x_wrap ? '0 : x_q + X_BITS'(1);
        y_d     = y_q;
        frame_d = frame_q;
        if (x_wrap) begin
            y_d = y_wrap ? '0 : y_q + Y_BITS'(1);
            if (y_wrap && pause_n) frame_d = frame_q + F_BITS'(1);
        end
    end

    always_ff @(posedge clk48 or posedge rst) begin
        if (rst) begin
            x_q     <= '0;
            y_q     <= '0;
            frame_q <= '0;
        end else begin
            x_q     <= x_d;
            y_q     <= y_d;
            frame_q <= frame_d;
        end
    end

    assign x           = x_q;
    assign y           = y_q;
    assign frame       = frame_q;
    assign line_start  = (x_q == '0);
    assign frame_start = (x_q == '0) && (y_q == '0);

    pix_meta_t meta_raw, meta_al;

    always_comb begin
        meta_raw.active = (x_q < H_ACT) && (y_q < V_ACT);
        meta_raw.hs     = (x_q >= HS_BEG) && (x_q < HS_END);
        meta_raw.vs     = (y_q >= VS_BEG) && (y_q < VS_END);
        meta_raw.xs     = x_q[2:0];
        meta_raw.ys     = y_q[2:0];
        meta_raw.f0     = frame_q[0];
    end

    vga_delay_line #(
        .WIDTH($bits(pix_meta_t)),
        .DEPTH(LAT)
    ) u_align (
        .clk(clk48),
        .rst(rst),
        .d_i(meta_raw),
        .q_o(meta_al)
    );

    logic [4:0]          bayer, thresh;
    logic                unused_ys0;
    logic                hsync_q, hsync_d, vsync_q, vsync_d, de_q, de_d;
    logic [OUT_BITS-1:0] r_q, r_d, g_q, g_d, b_q, b_d;

    assign unused_ys0 = meta_al.ys[0];
    assign bayer      = bayer5(meta_al.xs, meta_al.ys[2:1], meta_al.f0);
    assign thresh     = bayer >> (5 - SHIFT);

    always_comb begin
        hsync_d = meta_al.hs ? HSYNC_POL : ~HSYNC_POL;
        vsync_d = meta_al.vs ? VSYNC_POL : ~VSYNC_POL;
        de_d    = meta_al.active;
        r_d     = '0;
        g_d     = '0;
        b_d     = '0;
        if (meta_al.active) begin
            r_d = OUT_BITS'(dither_sat(32'(r_in), 32'(thresh), SHIFT, OUT_BITS));
            g_d = OUT_BITS'(dither_sat(32'(g_in), 32'(thresh), SHIFT, OUT_BITS));
            b_d = OUT_BITS'(dither_sat(32'(b_in), 32'(thresh), SHIFT, OUT_BITS));
        end
    end

    // Reset parks the sync pins at their inactive level, not at zero.
    always_ff @(posedge clk48 or posedge rst) begin
        if (rst) begin
            hsync_q <= ~HSYNC_POL;
            vsync_q <= ~VSYNC_POL;
            de_q    <= 1'b0;
            r_q     <= '0;
            g_q     <= '0;
            b_q     <= '0;
        end else begin
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
            de_q    <= de_d;
            r_q     <= r_d;
            g_q     <= g_d;
            b_q     <= b_d;
        end
    end

    assign hsync = hsync_q;
    assign vsync = vsync_q;
    assign de    = de_q;
    assign r_out = r_q;
    assign g_out = g_q;
    assign b_out = b_q;

endmodule

// File: tb/tb_vga_scanout.sv
// Bench for vga_scanout on a tiny 16x8 raster: cycle-by-cycle comparison
// against a queue-based reference plus hand-computed scenario checks.
module tb_vga_scanout;

    localparam int LAT = 2;

    logic        clk48 = 1'b0;
    logic        rst = 1'b1;
    logic        pause_n = 1'b1;
    logic [10:0] x;
    logic [9:0]  y;
    logic [10:0] frame;
    logic        line_start, frame_start;
    logic [5:0]  r_in = '0, g_in = '0, b_in = '0;
    logic        hsync, vsync, de;
    logic [1:0]  r_out, g_out, b_out;

    vga_scanout #(
        .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
        .V_DISPLAY(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
        .HSYNC_POL(1'b0), .VSYNC_POL(1'b0),
        .IN_BITS(6), .OUT_BITS(2), .LAT(LAT)
    ) dut (
        .clk48(clk48), .rst(rst), .pause_n(pause_n),
        .x(x), .y(y), .frame(frame),
        .line_start(line_start), .frame_start(frame_start),
        .r_in(r_in), .g_in(g_in), .b_in(b_in),
        .hsync(hsync), .vsync(vsync), .de(de),
        .r_out(r_out), .g_out(g_out), .b_out(b_out)
    );

    always #5 clk48 = ~clk48;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference: count index mk since reset, raster is 16 clocks x 8 lines.
    function automatic int dith(input int c, input int px, input int py, input int pf);
        int i, j, b5, t, v;
        i  = (px % 8) ^ ((pf % 2 == 1) ? 7 : 0);
        j  = py % 8;
        b5 = ((i & 1) << 4) | ((((i >> 1) ^ (j >> 1)) & 1) << 3) | (((i >> 1) & 1) << 2)
           | ((((i >> 2) ^ (j >> 2)) & 1) << 1) | ((i >> 2) & 1);
        t  = b5 >> 1;
        v  = (c + t) >> 4;
        return (v > 3) ? 3 : v;
    endfunction

    typedef struct {
        bit v;
        int x;
        int y;
        int f;
    } ent_t;

    ent_t pipe[$];
    ent_t ma, mc, e_al;
    int   mk = 0, mf = 0;
    bit   e_hsync = 1'b1, e_vsync = 1'b1, e_de = 1'b0;
    int   e_r = 0, e_g = 0, e_b = 0;

    always @(posedge clk48 or posedge rst) begin
        if (rst) begin
            mk = 0;
            mf = 0;
            pipe.delete();
            ma = '{v: 1'b0, x: 0, y: 0, f: 0};
            for (int i = 0; i < LAT; i++) pipe.push_back(ma);
            e_al = ma;
            e_hsync = 1'b1; e_vsync = 1'b1; e_de = 1'b0;
            e_r = 0; e_g = 0; e_b = 0;
        end else begin
            ma = pipe.pop_front();
            e_al = ma;
            e_de    = ma.v && ma.x < 8 && ma.y < 4;
            e_hsync = !(ma.v && ma.x >= 10 && ma.x < 13);
            e_vsync = !(ma.v && ma.y >= 5 && ma.y < 7);
            e_r = e_de ? dith(int'(r_in), ma.x, ma.y, ma.f) : 0;
            e_g = e_de ? dith(int'(g_in), ma.x, ma.y, ma.f) : 0;
            e_b = e_de ? dith(int'(b_in), ma.x, ma.y, ma.f) : 0;
            mc = '{v: 1'b1, x: mk % 16, y: (mk / 16) % 8, f: mf};
            pipe.push_back(mc);
            if (mk % 128 == 127 && pause_n) mf = (mf + 1) % 2048;
            mk++;
        end
    end

    bit run_chk = 0, cnt_on = 0, zero_on = 0, sat_on = 0, rec_on = 0;
    int hs_low = 0, vs_low = 0, rnz = 0, de_cnt = 0, r3_cnt = 0;
    int rec_r [2][8];
    int rec_g [2][8];

    initial begin
        for (int p = 0; p < 2; p++)
            for (int i = 0; i < 8; i++) begin
                rec_r[p][i] = -1;
                rec_g[p][i] = -1;
            end
    end

    always @(negedge clk48) begin
        if (run_chk) begin
            chk("x", int'(x), mk % 16);
            chk("y", int'(y), (mk / 16) % 8);
            chk("frame", int'(frame), mf);
            chk("line_start", int'(line_start), int'(mk % 16 == 0));
            chk("frame_start", int'(frame_start), int'(mk % 128 == 0));
            chk("hsync", int'(hsync), int'(e_hsync));
            chk("vsync", int'(vsync), int'(e_vsync));
            chk("de", int'(de), int'(e_de));
            chk("r_out", int'(r_out), e_r);
            chk("g_out", int'(g_out), e_g);
            chk("b_out", int'(b_out), e_b);
            if (cnt_on) begin
                if (!hsync) hs_low++;
                if (!vsync) vs_low++;
            end
            if (zero_on && r_out != 0) rnz++;
            if (sat_on && de) begin
                de_cnt++;
                if (r_out == 2'd3) r3_cnt++;
            end
            if (rec_on && e_al.v && e_al.y == 0 && e_al.x < 8) begin
                rec_r[e_al.f % 2][e_al.x] = int'(r_out);
                rec_g[e_al.f % 2][e_al.x] = int'(g_out);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk48);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int g_even [8];
        int g_odd [8];
        g_even = '{2, 3, 2, 3, 2, 3, 2, 3};
        g_odd  = '{3, 2, 3, 2, 3, 2, 3, 2};

        tick(3);
        run_chk = 1;
        chk("rst_hsync_idle", int'(hsync), 1);
        chk("rst_de_idle", int'(de), 0);

        // Free run, three frames.
        r_in = 6'd10; g_in = 6'd33; b_in = 6'd50;
        cnt_on = 1;
        rst = 1'b0;
        tick(384);
        cnt_on = 0;
        chk("free_frame", int'(frame), 3);
        chk("free_hs_low", hs_low, 72);
        chk("free_vs_low", vs_low, 96);

        // Pause across a frame wrap, zero red input.
        pause_n = 1'b0;
        r_in = 6'd0; g_in = 6'd21; b_in = 6'd62;
        tick(4);
        zero_on = 1;
        tick(196);
        zero_on = 0;
        chk("pause_frame_hold", int'(frame), 3);
        chk("zero_r_nonzero", rnz, 0);
        pause_n = 1'b1;

        // Full-scale red saturates.
        r_in = 6'd63; g_in = 6'd3; b_in = 6'd45;
        tick(4);
        sat_on = 1;
        tick(128);
        sat_on = 0;
        chk("sat_de_count", de_cnt, 32);
        chk("sat_r3_count", r3_cnt, 32);

        // Dither pattern on row 0, both frame parities.
        r_in = 6'd32; g_in = 6'd40; b_in = 6'd20;
        tick(4);
        rec_on = 1;
        tick(300);
        rec_on = 0;
        for (int i = 0; i < 8; i++) begin
            chk("dith_r_even", rec_r[0][i], 2);
            chk("dith_r_odd", rec_r[1][i], 2);
            chk("dith_g_even", rec_g[0][i], g_even[i]);
            chk("dith_g_odd", rec_g[1][i], g_odd[i]);
        end

        // Reset pulse at x=5, y=2.
        n = 0;
        while (!(mk % 16 == 5 && (mk / 16) % 8 == 2) && n < 300) begin
            tick(1);
            n++;
        end
        chk("rst_point_reached", int'(n < 300), 1);
        chk("pre_rst_de", int'(de), 1);
        chk("pre_rst_r", int'(r_out), 2);
        rst = 1'b1;
        #1;
        chk("rst_now_hsync", int'(hsync), 1);
        chk("rst_now_vsync", int'(vsync), 1);
        chk("rst_now_de", int'(de), 0);
        chk("rst_now_r", int'(r_out), 0);
        chk("rst_now_x", int'(x), 0);
        tick(3);
        rst = 1'b0;
        @(negedge clk48);
        chk("rel_frame_start", int'(frame_start), 1);
        chk("rel_de_c0", int'(de), 0);
        @(negedge clk48);
        chk("rel_de_c1", int'(de), 0);
        @(negedge clk48);
        chk("rel_de_c2", int'(de), 0);
        @(negedge clk48);
        chk("rel_de_c3", int'(de), 1);
        chk("rel_r_c3", int'(r_out), 2);
        tick(20);
        run_chk = 0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vga_scanout.md
VGA_SCANOUT -- requirements
Module: vga_scanout

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- H_DISPLAY, 1220, active pixels per line.
- H_FRONT, 31, horizontal front porch in clocks.
- H_SYNC, 183, hsync pulse width in clocks.
- H_BACK, 92, horizontal back porch in clocks.
- V_DISPLAY, 480, active lines.
- V_FRONT, 10, vertical front porch in lines.
- V_SYNC, 2, vsync width in lines.
- V_BACK, 33, vertical back porch in lines.
- HSYNC_POL, 0, asserted level of hsync.
- VSYNC_POL, 0, asserted level of vsync.
- IN_BITS, 6, input colour bits per channel.
- OUT_BITS, 2, output bits per channel.
- LAT, 2, upstream pixel latency in clocks (0..15).
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clk48, in, 1, sole clock.
- rst, in, 1, asynchronous active-high reset.
- pause_n, in, 1, low freezes the frame counter.
- x, out, 11, current h count.
- y, out, 10, current v count.
- frame, out, 11, frame counter.
- line_start, out, 1, one-clock strobe at h count 0.
- frame_start, out, 1, one-clock strobe at h=0, v=0.
- r_in, in, IN_BITS, red, valid LAT clocks after its x/y.
- g_in, in, IN_BITS, green, same timing as r_in.
- b_in, in, IN_BITS, blue, same timing as r_in.
- hsync, out, 1, registered hsync.
- vsync, out, 1, registered vsync.
- de, out, 1, registered display enable.
- r_out, out, OUT_BITS, dithered red.
- g_out, out, OUT_BITS, dithered green.
- b_out, out, OUT_BITS, dithered blue.

Function
REQ-003 H_TOTAL SHALL be the sum of the four H parameters and V_TOTAL the sum of the four V parameters; x SHALL count 0..H_TOTAL-1 and wrap, and y SHALL increment on each x wrap and wrap at V_TOTAL-1.
REQ-004 frame SHALL increment by 1 (mod 2^11) on the y wrap only when pause_n=1 on that clock; counters keep running while paused.
REQ-005 line_start and frame_start SHALL be combinational decodes of the counters, aligned with x and y.
REQ-006 For each count (x,y), the raw signals SHALL be: active = x<H_DISPLAY and y<V_DISPLAY; hs = H_DISPLAY+H_FRONT <= x < H_DISPLAY+H_FRONT+H_SYNC; vs is the same form on y.
REQ-007 raw active, hs, vs, x[2:0], y[2:0] and frame[0] SHALL be delayed LAT clocks to align with r_in/g_in/b_in, then all outputs registered once, giving a total latency of LAT+1 clocks from count to pins.
REQ-008 hsync SHALL equal HSYNC_POL when the aligned hs=1, else its complement; vsync SHALL follow the same rule with VSYNC_POL.
REQ-009 Bayer index SHALL be computed as: i = aligned x[2:0] XOR {3{frame[0]}}, j = aligned y[2:0], bayer5 = {i0, i1^j1, i1, i2^j2, i2}.
REQ-010 With S = IN_BITS-OUT_BITS (1..5), the threshold SHALL be t = bayer5 >> (5-S).
REQ-011 Each output channel SHALL be min((c + t) >> S, 2^OUT_BITS-1), computed without overflow; the saturation is required so the full-scale code is reachable.
REQ-012 When the aligned active=0, de and all colour outputs SHALL be 0 regardless of the inputs.
REQ-013 Parameter combinations with S outside 1..5 or LAT>15 SHALL be rejected at elaboration.

Reset
REQ-014 rst SHALL asynchronously clear x, y, frame and every delay stage.
REQ-015 During reset, hsync and vsync SHALL hold their deasserted levels and de, r_out, g_out and b_out SHALL be 0.
REQ-016 After rst deasserts, x=0 and y=0 on the first clock, frame_start SHALL be 1, and the first valid pixel SHALL appear LAT+1 clocks later.
REQ-017 Reset asserted mid-frame SHALL discard the in-flight pipeline contents, with no stale de or colour output after release.

Structure
REQ-018 The Bayer function, the dither/saturate function and the timing-total constants SHALL live in a shared package vga_pkg.
REQ-019 The LAT-deep alignment delay SHALL be one sub-module, vga_delay_line, parametrised in width and depth, where depth 0 is a wire.

Verification
REQ-020 The bench SHALL use H=8/2/3/3, V=4/1/2/1, LAT=2 and cover these scenarios:
- Counters: free run 3 frames -> hsync low exactly for x=10..12 shifted 3 clocks, vsync low for y=5..6, frame=3.
- Pause: pause_n=0 across one wrap -> frame holds, sync timing unchanged.
- Saturation: r_in=63 at all pixels, 6->2 bits -> r_out=3 at every active pixel.
- Zero input: r_in=0 -> r_out=0 everywhere.
- Dither pattern: r_in=32, frame even, y=0 row -> r_out pattern over x0..7 matches the REQ-011 formula; next frame shows the toggled pattern.
- Reset: rst pulsed at x=5, y=2 -> outputs go to idle levels immediately; after release frame_start=1 at the first clock and the first de appears 3 clocks later.
